// File: rtl/ahb_policy_pkg.sv
// rtl/ahb_policy_pkg.sv - shared constants and types for the AHB policy configuration slave
// Contents: register map bases/strides, entry field offsets, transfer size,
// CTRL/STATUS bit positions and the bus FSM state type.
package ahb_policy_pkg;

    localparam logic [11:0] APU_BASE   = 12'h000;
    localparam logic [11:0] DPU_BASE   = 12'h400;
    localparam logic [11:0] CTRL_OFS   = 12'h800;
    localparam logic [11:0] STATUS_OFS = 12'h804;

    localparam int APU_STRIDE = 16;
    localparam int DPU_STRIDE = 32;
    localparam int APU_SHIFT  = $clog2(APU_STRIDE);
    localparam int DPU_SHIFT  = $clog2(DPU_STRIDE);

    // Word index of each field inside an entry
    localparam int APU_MID   = 0;
    localparam int APU_ADDR  = 1;
    localparam int APU_MASK  = 2;
    localparam int APU_PERM  = 3;
    localparam int DPU_MID   = 0;
    localparam int DPU_ADDR  = 1;
    localparam int DPU_DATA  = 2;
    localparam int DPU_MASK  = 3;
    localparam int DPU_AMASK = 4;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam int CTRL_COMMIT_BIT  = 0;
    localparam int CTRL_LOCK_BIT    = 1;
    localparam int STATUS_LOCK_BIT  = 0;
    localparam int STATUS_DIRTY_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

endpackage

// File: rtl/ahb_policy_addr_decode.sv
// rtl/ahb_policy_addr_decode.sv - combinational decode of the 12-bit register offset
// Ports: addr (offset) in; is_apu/is_dpu/is_ctrl/is_status region hits,
// index (entry number), field (word within entry), mapped (any legal hit) out.
module ahb_policy_addr_decode
    import ahb_policy_pkg::*;
#(
    parameter int NUM_APU_POLICY = 16,
    parameter int NUM_DPU_POLICY = 16
) (
    input  logic [11:0] addr,
    output logic        is_apu,
    output logic        is_dpu,
    output logic        is_ctrl,
    output logic        is_status,
    output logic [5:0]  index,
    output logic [2:0]  field,
    output logic        mapped
);

    logic       in_apu;
    logic       in_dpu;
    logic [5:0] apu_idx;
    logic [5:0] dpu_idx;
    logic [2:0] apu_fld;
    logic [2:0] dpu_fld;

    always_comb begin
        in_apu  = (addr[11:10] == APU_BASE[11:10]);
        in_dpu  = (addr[11:10] == DPU_BASE[11:10]);
        apu_idx = addr[APU_SHIFT+5:APU_SHIFT];
        apu_fld = {1'b0, addr[APU_SHIFT-1:2]};
        dpu_idx = {1'b0, addr[DPU_SHIFT+4:DPU_SHIFT]};
        dpu_fld = addr[DPU_SHIFT-1:2];

        // Entries past the configured count, and the three spare DPU words, are holes
        is_apu    = in_apu && (int'(apu_idx) < NUM_APU_POLICY);
        is_dpu    = in_dpu && (int'(dpu_idx) < NUM_DPU_POLICY) && (dpu_fld <= 3'(DPU_AMASK));
        is_ctrl   = (addr == CTRL_OFS);
        is_status = (addr == STATUS_OFS);
        index     = in_dpu ? dpu_idx : apu_idx;
        field     = in_dpu ? dpu_fld : apu_fld;
        mapped    = is_apu | is_dpu | is_ctrl | is_status;
    end

endmodule

// File: rtl/ahb_policy_cfg_slave.sv
// rtl/ahb_policy_cfg_slave.sv - AHB-lite slave holding shadow/active APU and DPU policy tables
// Ports: hclk/hresetn clock and sync active-low reset; hsel, hready, haddr, hmaster,
// hsize, hwrite, hwdata bus inputs; hrdata, hreadyout, hresp bus outputs;
// apu*/dpu* active policy vectors, updated only by a COMMIT write to CTRL.
module ahb_policy_cfg_slave
    import ahb_policy_pkg::*;
#(
    parameter int NUM_APU_POLICY = 16,
    parameter int NUM_DPU_POLICY = 16
) (
    input  logic                             hclk,
    input  logic                             hresetn,
    input  logic                             hsel,
    input  logic                             hready,
    input  logic [31:0]                      haddr,
    input  logic [31:0]                      hmaster,
    input  logic [2:0]                       hsize,
    input  logic                             hwrite,
    input  logic [31:0]                      hwdata,
    output logic [31:0]                      hrdata,
    output logic                             hreadyout,
    output logic                             hresp,
    output logic [NUM_APU_POLICY-1:0][31:0]  apumid,
    output logic [NUM_APU_POLICY-1:0][31:0]  apuaddr,
    output logic [NUM_APU_POLICY-1:0][31:0]  apumask,
    output logic [NUM_APU_POLICY-1:0][31:0]  apuperm,
    output logic [NUM_DPU_POLICY-1:0][31:0]  dpumid,
    output logic [NUM_DPU_POLICY-1:0][31:0]  dpuaddr,
    output logic [NUM_DPU_POLICY-1:0][31:0]  dpudata,
    output logic [NUM_DPU_POLICY-1:0][31:0]  dpumask,
    output logic [NUM_DPU_POLICY-1:0][31:0]  dpuamask
);

    state_t state;

    logic [NUM_APU_POLICY-1:0][3:0][31:0] sh_apu;
    logic [NUM_DPU_POLICY-1:0][4:0][31:0] sh_dpu;
    logic lock;
    logic dirty;

    // Address-phase decode
    logic       d_is_apu, d_is_dpu, d_is_ctrl, d_is_status, d_mapped;
    logic [5:0] d_index;
    logic [2:0] d_field;

    // Data-phase copies of the decode
    logic       dp_is_apu, dp_is_dpu, dp_is_ctrl, dp_is_status, dp_write;
    logic [5:0] dp_index;
    logic [2:0] dp_field;

    logic        take;
    logic        wr_fire;
    logic        lock_eff;
    logic        priv;
    logic        addr_err;
    logic [31:0] rd_word;
    logic        unused_ok;

    assign unused_ok = ^{haddr[31:12], hmaster[0]};

    ahb_policy_addr_decode #(
        .NUM_APU_POLICY (NUM_APU_POLICY),
        .NUM_DPU_POLICY (NUM_DPU_POLICY)
    ) u_decode (
        .addr      (haddr[11:0]),
        .is_apu    (d_is_apu),
        .is_dpu    (d_is_dpu),
        .is_ctrl   (d_is_ctrl),
        .is_status (d_is_status),
        .index     (d_index),
        .field     (d_field),
        .mapped    (d_mapped)
    );

    assign take    = hsel & hready & (state != ST_ERR1);
    assign wr_fire = (state == ST_DATA) & dp_write;
    assign priv    = ~|hmaster[31:1];

    // A LOCK write completing on this edge must already block the address phase
    // sampled on the same edge, otherwise a pipelined write would slip through.
    assign lock_eff = lock | (wr_fire & dp_is_ctrl & hwdata[CTRL_LOCK_BIT]);

    assign addr_err = ~d_mapped
                    | (hsize != HSIZE_WORD)
                    | (haddr[1:0] != 2'b00)
                    | (hwrite & (~priv | d_is_status
                                 | (lock_eff & (d_is_apu | d_is_dpu | d_is_ctrl))));

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state        <= ST_IDLE;
            hreadyout    <= 1'b1;
            hresp        <= 1'b0;
            dp_is_apu    <= 1'b0;
            dp_is_dpu    <= 1'b0;
            dp_is_ctrl   <= 1'b0;
            dp_is_status <= 1'b0;
            dp_write     <= 1'b0;
            dp_index     <= '0;
            dp_field     <= '0;
        end else if (state == ST_ERR1) begin
            state     <= ST_ERR2;
            hreadyout <= 1'b1;
            hresp     <= 1'b1;
        end else if (take) begin
            dp_is_apu    <= d_is_apu;
            dp_is_dpu    <= d_is_dpu;
            dp_is_ctrl   <= d_is_ctrl;
            dp_is_status <= d_is_status;
            dp_write     <= hwrite;
            dp_index     <= d_index;
            dp_field     <= d_field;
            if (addr_err) begin
                state     <= ST_ERR1;
                hreadyout <= 1'b0;
                hresp     <= 1'b1;
            end else begin
                state     <= ST_DATA;
                hreadyout <= 1'b1;
                hresp     <= 1'b0;
            end
        end else begin
            state     <= ST_IDLE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
        end
    end

    // Only error-free writes reach ST_DATA, so wr_fire needs no further qualification
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            sh_apu   <= '0;
            sh_dpu   <= '0;
            apumid   <= '0;
            apuaddr  <= '0;
            apumask  <= '0;
            apuperm  <= '0;
            dpumid   <= '0;
            dpuaddr  <= '0;
            dpudata  <= '0;
            dpumask  <= '0;
            dpuamask <= '0;
            lock     <= 1'b0;
            dirty    <= 1'b0;
        end else if (wr_fire) begin
            if (dp_is_apu) begin
                for (int i = 0; i < NUM_APU_POLICY; i++)
                    if (dp_index == 6'(i)) sh_apu[i][dp_field[1:0]] <= hwdata;
                dirty <= 1'b1;
            end
            if (dp_is_dpu) begin
                for (int j = 0; j < NUM_DPU_POLICY; j++)
                    if (dp_index == 6'(j)) sh_dpu[j][dp_field] <= hwdata;
                dirty <= 1'b1;
            end
            if (dp_is_ctrl) begin
                if (hwdata[CTRL_COMMIT_BIT]) begin
                    for (int i = 0; i < NUM_APU_POLICY; i++) begin
                        apumid[i]  <= sh_apu[i][APU_MID];
                        apuaddr[i] <= sh_apu[i][APU_ADDR];
                        apumask[i] <= sh_apu[i][APU_MASK];
                        apuperm[i] <= sh_apu[i][APU_PERM];
                    end
                    for (int j = 0; j < NUM_DPU_POLICY; j++) begin
                        dpumid[j]   <= sh_dpu[j][DPU_MID];
                        dpuaddr[j]  <= sh_dpu[j][DPU_ADDR];
                        dpudata[j]  <= sh_dpu[j][DPU_DATA];
                        dpumask[j]  <= sh_dpu[j][DPU_MASK];
                        dpuamask[j] <= sh_dpu[j][DPU_AMASK];
                    end
                    dirty <= 1'b0;
                end
                if (hwdata[CTRL_LOCK_BIT]) lock <= 1'b1;
            end
        end
    end

    // Read data is a mux of current shadow state, so a read right behind a write
    // to the same word already sees the committed value.
    always_comb begin
        rd_word = '0;
        if (dp_is_apu) begin
            for (int i = 0; i < NUM_APU_POLICY; i++)
                if (dp_index == 6'(i)) rd_word = sh_apu[i][dp_field[1:0]];
        end
        if (dp_is_dpu) begin
            for (int j = 0; j < NUM_DPU_POLICY; j++)
                if (dp_index == 6'(j)) rd_word = sh_dpu[j][dp_field];
        end
        if (dp_is_ctrl)
            rd_word[CTRL_LOCK_BIT] = lock;
        if (dp_is_status) begin
            rd_word[23:16]            = 8'(NUM_DPU_POLICY);
            rd_word[15:8]             = 8'(NUM_APU_POLICY);
            rd_word[STATUS_DIRTY_BIT] = dirty;
            rd_word[STATUS_LOCK_BIT]  = lock;
        end
        hrdata = ((state == ST_DATA) && !dp_write) ? rd_word : 32'h0;
    end

endmodule

// File: doc/ahb_policy_cfg_slave.md
Name: ahb_policy_cfg_slave

Overview:
AHB-lite responder that owns the APU/DPU policy tables consumed by the transaction monitor, and drives its policy vectors. Privileged masters write entries into a shadow bank. A single COMMIT write copies the whole shadow bank to the active outputs in one cycle, so the monitor never evaluates a half-written policy. A sticky LOCK freezes all configuration until reset. The block sits on the interconnect as an ordinary slave, behind its own monitor instance or on a privileged-only port.

Parameters:
NUM_APU_POLICY, 16, APU entries; legal range 1..64.
NUM_DPU_POLICY, 16, DPU entries; legal range 1..32.

Ports:
hclk  in  1  clock
hresetn  in  1  reset; synchronous, active-low
hsel  in  1  slave select
hready  in  1  bus ready; an address phase is taken when hsel & hready
haddr  in  32  address; only [11:0] decoded
hmaster  in  32  master id; privileged when |hmaster[31:1]==0
hsize  in  3  transfer size
hwrite  in  1  write control
hwdata  in  32  write data, valid in data phase
hrdata  out  32  read data
hreadyout  out  1  slave ready
hresp  out  1  error response
apumid, apuaddr, apumask, apuperm  out  [NUM_APU_POLICY-1:0][32]  active APU policy
dpumid, dpuaddr, dpudata, dpumask, dpuamask  out  [NUM_DPU_POLICY-1:0][32]  active DPU policy

Behaviour:
- Reset (hresetn==0 at posedge hclk): hreadyout=1, hresp=0, hrdata=0, all shadow and active entries 0, LOCK=0, DIRTY=0, FSM=IDLE.
- Memory map (byte offsets, haddr[11:0]):
  - APU entry i at 0x000+16*i: +0 mid, +4 addr, +8 mask, +C perm.
  - DPU entry j at 0x400+32*j: +0 mid, +4 addr, +8 data, +C mask, +10 amask; +14..+1C unmapped.
  - CTRL at 0x800: bit0 COMMIT (write-1, self-clearing, reads 0); bit1 LOCK (write-1 sticky).
  - STATUS at 0x804, read-only: bit0 LOCK, bit1 DIRTY, [15:8] NUM_APU_POLICY, [23:16] NUM_DPU_POLICY.
  - Anything else, or an index >= NUM_*, is unmapped.
- Address phase: latch haddr[11:0], hwrite, hsize, hmaster and the decode result into data-phase registers.
- Error conditions, evaluated at the address phase:
  - unmapped address;
  - hsize != 3'b010;
  - haddr[1:0] != 0;
  - write by an unprivileged master;
  - write to a policy entry or CTRL while LOCK=1;
  - write to STATUS.
  Reads by any master to mapped words are legal, including while locked.
- FSM states IDLE/DATA, ERR1, ERR2:
  - OK transfer: zero wait states. hreadyout=1, hresp=0 in the data phase.
  - Error transfer: ERR1 drives hreadyout=0, hresp=1. ERR2 drives hreadyout=1, hresp=1. Then IDLE/DATA.
  - No state change, shadow or control, results from an errored transfer.
  - An address phase sampled during ERR2 is accepted normally.
- Write commit: shadow word updated from hwdata at the posedge ending the data phase. Any shadow write sets DIRTY.
- Read: hrdata = shadow/STATUS word selected by the latched address during the data phase; 0 for writes and errors.
- Back-to-back write then read of the same word returns the new value with no wait state; no forwarding is needed because the read data phase follows the write commit.
- COMMIT write: active <= shadow on the posedge ending its data phase, so outputs change the next cycle. DIRTY clears at the same edge.
- CTRL write with bits1:0=11: commit and lock both take effect at the same edge.
- A shadow write and a COMMIT cannot coincide (single port).
- Reset mid-transfer, including in ERR1: all state returns to reset values immediately.

Decomposition:
- ahb_policy_pkg: region bases (APU_BASE=12'h000, DPU_BASE=12'h400, CTRL_OFS=12'h800, STATUS_OFS=12'h804), strides (16, 32), field offsets, HSIZE_WORD, CTRL/STATUS bit positions, FSM state enum.
- Sub-module ahb_policy_addr_decode (combinational): maps addr[11:0] to {is_apu, is_dpu, is_ctrl, is_status, index, field, mapped}.

Test Plan:
1. Reset, master 0 reads 0x804 -> hrdata=32'h0010_1000, hresp=0, zero wait.
2. Master 1 writes 0x030=32'h5, then reads 0x030:
   - read returns 5 and apumid[3] stays 0;
   - write CTRL=1 -> apumid[3]=5 the following cycle, STATUS bit1 returns to 0.
3. Master id 2 writes 0x400 -> ERR1 (hreadyout=0, hresp=1) then ERR2 (1,1); shadow dpumid[0] unchanged; a read of 0x400 by master 2 is OK.
4. Write CTRL=2, then master 0 writes 0x004 -> two-cycle error. Read 0x804 -> bit0=1. After hresetn pulse -> LOCK=0, all outputs 0.
5. Each of hsize=3'b001, haddr=0x032, haddr=0x900, haddr=0x414, haddr=0x600 (DPU index 16) -> two-cycle error, no state change.
6. Back-to-back write 0x410=A5A5_A5A5, read 0x410, COMMIT -> read returns A5A5_A5A5 with no stall; dpuamask[0]=A5A5_A5A5 after the commit.
